// File: rtl/count_ser_pkg.sv
// count_ser_pkg: shared types and constants for the count_serializer block.
//   - state_t   : frame FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   - *_DEF     : default build configuration
//   - DIV_W     : bit-period divider width for the default CLK_DIV
//   - IDX_W     : bit-index width for the default DATA_W
//   - width_of(): counter width for a count range, never below 1 bit
//   - max_int() : larger of two integers
package count_ser_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int CLK_DIV_DEF   = 4;
    localparam int STOP_BITS_DEF = 1;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int DIV_W = width_of(CLK_DIV_DEF);
    localparam int IDX_W = width_of(DATA_W_DEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

endpackage

// File: rtl/count_serializer_bit_tick_gen.sv
// bit_tick_gen: bit-period divider for the serializer.
//   Counts CLK_DIV enabled cycles and flags the last one with bit_end.
// Ports:
//   clk     in   clock, all state on rising edge
//   rst     in   synchronous active-high reset
//   ena     in   enable; 0 freezes the count and suppresses bit_end
//   clr     in   synchronous clear (held while the FSM is idle)
//   bit_end out  high during the last enabled cycle of each bit period
module bit_tick_gen
    import count_ser_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int CNT_W   = DIV_W
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clr,
    output logic bit_end
);

    logic [CNT_W-1:0] div;

    assign bit_end = ena && (div == CNT_W'(CLK_DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (ena) begin
            if (clr || bit_end) begin
                div <= '0;
            end else begin
                div <= div + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/count_serializer.sv
// count_serializer: sends an 8-bit counter snapshot as a UART-style frame
// (start bit, data LSB-first, optional even parity, stop bit(s)) on one pin.
// Optional feature: define COUNT_SER_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bits.
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset, aborts any frame
//   ena        in   tile enable; 0 freezes all state
//   cnt_in     in   snapshot to send
//   cnt_valid  in   cnt_in valid this cycle
//   cnt_ready  out  snapshot accepted on this edge if cnt_valid
//   tx_ser     out  registered serial line, idle high
//   tx_busy    out  frame in progress
//   frame_done out  one-cycle pulse in the first idle cycle after a frame
module count_serializer
    import count_ser_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int STOP_BITS = STOP_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [DATA_W-1:0] cnt_in,
    input  logic              cnt_valid,
    output logic              cnt_ready,
    output logic              tx_ser,
    output logic              tx_busy,
    output logic              frame_done
);

    localparam int CNT_BITS = width_of(CLK_DIV);
    // The bit index also counts stop bits, so it covers both ranges.
    localparam int IDX_BITS = max_int(IDX_W, max_int(width_of(DATA_W), width_of(STOP_BITS)));

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n, shreg_shift;
    logic [IDX_BITS-1:0] idx, idx_n;
    logic                tx_q, tx_n;
    logic                done_q, done_n;
    logic                bit_end;
`ifdef COUNT_SER_PARITY_EN
    logic                par_q, par_n;
`endif

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_BITS)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .clr     (state == S_IDLE),
        .bit_end (bit_end)
    );

    assign cnt_ready   = (state == S_IDLE) && ena;
    assign shreg_shift = shreg >> 1;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
        tx_n    = tx_q;
        done_n  = 1'b0;
`ifdef COUNT_SER_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            S_IDLE: begin
                if (cnt_valid && cnt_ready) begin
                    state_n = S_START;
                    shreg_n = cnt_in;
                    idx_n   = '0;
                    tx_n    = 1'b0;
`ifdef COUNT_SER_PARITY_EN
                    par_n   = ^cnt_in;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    tx_n    = shreg[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    // After DATA_W shifts the register is all zeros again.
                    shreg_n = shreg_shift;
                    if (idx == IDX_BITS'(DATA_W - 1)) begin
                        idx_n = '0;
`ifdef COUNT_SER_PARITY_EN
                        state_n = S_PARITY;
                        tx_n    = par_q;
`else
                        state_n = S_STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n = idx + IDX_BITS'(1);
                        tx_n  = shreg_shift[0];
                    end
                end
            end
`ifdef COUNT_SER_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (idx == IDX_BITS'(STOP_BITS - 1)) begin
                        state_n = S_IDLE;
                        idx_n   = '0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n = idx + IDX_BITS'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            idx    <= '0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
`ifdef COUNT_SER_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else if (ena) begin
            state  <= state_n;
            shreg  <= shreg_n;
            idx    <= idx_n;
            tx_q   <= tx_n;
            done_q <= done_n;
`ifdef COUNT_SER_PARITY_EN
            par_q  <= par_n;
`endif
        end else begin
            done_q <= 1'b0;
        end
    end

    assign tx_ser     = tx_q;
    assign tx_busy    = (state != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_count_serializer.sv
// tb_count_serializer: self-checking bench for count_serializer.
// Inputs are driven on the falling edge; outputs are sampled shortly after it.
// Accepted snapshots go into a scoreboard queue; a monitor pops them when a
// frame starts and compares every enabled cycle of tx_ser against the
// expected start/data/parity/stop waveform.
module tb_count_serializer;

    localparam int DATA_W    = 8;
    localparam int CLK_DIV   = 4;
    localparam int STOP_BITS = 1;
`ifdef COUNT_SER_PARITY_EN
    localparam int PAR_BITS  = 1;
`else
    localparam int PAR_BITS  = 0;
`endif
    localparam int FLEN = CLK_DIV * (1 + DATA_W + PAR_BITS + STOP_BITS);

    logic              clk;
    logic              rst;
    logic              ena;
    logic [DATA_W-1:0] cnt_in;
    logic              cnt_valid;
    logic              cnt_ready;
    logic              tx_ser;
    logic              tx_busy;
    logic              frame_done;

    count_serializer #(
        .DATA_W    (DATA_W),
        .CLK_DIV   (CLK_DIV),
        .STOP_BITS (STOP_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .cnt_in     (cnt_in),
        .cnt_valid  (cnt_valid),
        .cnt_ready  (cnt_ready),
        .tx_ser     (tx_ser),
        .tx_busy    (tx_busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] sb_q[$];
    bit                expect_abort = 1'b0;

    bit                mon_in_frame = 1'b0;
    int                mon_k        = 0;
    logic [DATA_W-1:0] mon_cur      = '0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                stall_at;
        int                stall_len;
        int                exp_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference waveform: k counts enabled cycles since the frame began.
    function automatic logic exp_bit(input logic [DATA_W-1:0] d, input int k);
        int b;
        b = k / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= DATA_W) return d[b-1];
`ifdef COUNT_SER_PARITY_EN
        if (b == DATA_W + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Monitor: sampled after the driver has set the inputs for the next edge,
    // so 'ena' here tells whether the current cycle counts toward the bit.
    initial begin
        forever begin
            logic exp_done;
            @(negedge clk);
            #2;
            exp_done = 1'b0;
            if (mon_in_frame && !tx_busy) begin
                if (expect_abort) begin
                    expect_abort = 1'b0;
                end else begin
                    check("frame_len", mon_k, FLEN);
                    exp_done = 1'b1;
                end
                mon_in_frame = 1'b0;
            end
            check("frame_done", frame_done, exp_done);
            if (!mon_in_frame && tx_busy) begin
                check("sb_frame_expected", sb_q.size(), 1);
                if (sb_q.size() != 0) mon_cur = sb_q.pop_front();
                mon_in_frame = 1'b1;
                mon_k        = 0;
            end
            if (mon_in_frame && ena && !rst) begin
                check($sformatf("tx_bit_%0h_k%0d", mon_cur, mon_k), tx_ser, exp_bit(mon_cur, mon_k));
                mon_k++;
            end
        end
    end

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic e, output bit acc);
        @(negedge clk);
        cnt_valid = v;
        cnt_in    = d;
        ena       = e;
        #1;
        acc = v && e && cnt_ready;
        if (acc) sb_q.push_back(d);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input int stall_at, input int stall_len,
                              input int exp_cyc, input string name);
        bit acc = 1'b0;
        int n0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, d, 1'b1, acc);
        check({name, "_accepted"}, acc, 1);
        if (!acc) return;
        n0 = cyc;
        for (int t = 1; t <= 200; t++) begin
            drive(1'b0, '0, !(t >= stall_at && t < stall_at + stall_len), acc);
            if (frame_done) break;
        end
        check({name, "_done_latency"}, cyc - n0, exp_cyc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int n1, n2;

        vecs.push_back('{data: 8'hA5, stall_at: 0,  stall_len: 0,  exp_cyc: FLEN + 1});
        vecs.push_back('{data: 8'h00, stall_at: 0,  stall_len: 0,  exp_cyc: FLEN + 1});
        vecs.push_back('{data: 8'hFF, stall_at: 12, stall_len: 10, exp_cyc: FLEN + 11});
        vecs.push_back('{data: 8'h80, stall_at: 0,  stall_len: 0,  exp_cyc: FLEN + 1});
`ifdef COUNT_SER_PARITY_EN
        vecs.push_back('{data: 8'h07, stall_at: 0,  stall_len: 0,  exp_cyc: FLEN + 1});
        vecs.push_back('{data: 8'h03, stall_at: 0,  stall_len: 0,  exp_cyc: FLEN + 1});
`endif

        // Reset state.
        rst       = 1'b1;
        ena       = 1'b1;
        cnt_valid = 1'b0;
        cnt_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_tx_ser", tx_ser, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_cnt_ready", cnt_ready, 1);
        ena = 1'b0;
        #1;
        check("ready_follows_ena", cnt_ready, 0);
        ena = 1'b1;
        rst = 1'b0;

        // Table-driven single frames, including a mid-DATA stall.
        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_cyc,
                       $sformatf("vec%0d", i));
        end

        // Back-to-back with cnt_valid held: second accept lands in the first
        // idle cycle, valid during busy is ignored.
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, 8'h01, 1'b1, acc);
        check("b2b_first_accepted", acc, 1);
        n1  = cyc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, 8'h02, 1'b1, acc);
        check("b2b_second_accepted", acc, 1);
        n2 = cyc;
        check("b2b_spacing", n2 - n1, FLEN + 1);
        for (int t = 1; t <= 200; t++) begin
            drive(1'b0, '0, 1'b1, acc);
            if (frame_done) break;
        end
        check("b2b_second_latency", cyc - n2, FLEN + 1);

        // Reset in DATA aborts the frame without a frame_done pulse.
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) drive(1'b1, 8'h5A, 1'b1, acc);
        check("abort_accepted", acc, 1);
        repeat (10) drive(1'b0, '0, 1'b1, acc);
        check("abort_busy_before", tx_busy, 1);
        expect_abort = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_tx_ser", tx_ser, 1);
        check("abort_tx_busy", tx_busy, 0);
        check("abort_frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (3) drive(1'b0, '0, 1'b1, acc);
        send_frame(8'h3C, 0, 0, FLEN + 1, "after_abort");

        repeat (3) drive(1'b0, '0, 1'b1, acc);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
